// File: rtl/eqn_cmp_pkg.sv
// Shared types and helpers for the registered equality comparator (eqn_cmp_seq).
// Holds the run-tracking FSM state enum and the width/saturation helpers.
package eqn_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    STABLE = 2'd2
  } state_e;

  // Run counter must hold the value HOLD itself.
  function automatic int run_width(input int hold);
    if (hold < 1) return 1;
    return $clog2(hold + 1);
  endfunction

  function automatic logic [31:0] sat_max(input int cnt_w);
    if (cnt_w >= 32) return '1;
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/eqn_cmp_core.sv
// Combinational WIDTH-bit unsigned comparator producing eq/gt/lt.
// With MATCH_MASK_EN defined both operands are ANDed with mask before comparing.
module eqn_cmp_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MATCH_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;

`ifdef MATCH_MASK_EN
  assign a_m = a & mask;
  assign b_m = b & mask;
`else
  assign a_m = a;
  assign b_m = b;
`endif

  assign eq = (a_m == b_m);
  assign gt = (a_m >  b_m);
  assign lt = (a_m <  b_m);

endmodule

// File: rtl/eqn_cmp_seq.sv
// Registered comparator with debounced equality (eq_stable after HOLD equal samples) and a saturating match count.
// One-cycle latency, no input-to-output combinational path; optional compare mask under MATCH_MASK_EN.
module eqn_cmp_seq
  import eqn_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MATCH_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             aeqb,
  output logic             agtb,
  output logic             altb,
  output logic             eq_stable,
  output logic             eq_rise,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               RUN_W   = run_width(HOLD);
  localparam logic [RUN_W-1:0] HOLD_R  = RUN_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic cmp_eq;
  logic cmp_gt;
  logic cmp_lt;

  eqn_cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a),
    .b    (b),
`ifdef MATCH_MASK_EN
    .mask (mask),
`endif
    .eq   (cmp_eq),
    .gt   (cmp_gt),
    .lt   (cmp_lt)
  );

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q,   run_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rise_q,  rise_d;
  logic             aeqb_q,  aeqb_d;
  logic             agtb_q,  agtb_d;
  logic             altb_q,  altb_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;

    // Flags follow every enabled sample, even one that coincides with clr.
    if (en) begin
      aeqb_d = cmp_eq;
      agtb_d = cmp_gt;
      altb_d = cmp_lt;
    end

    if (clr) begin
      state_d = IDLE;
      run_d   = '0;
      cnt_d   = '0;
    end else if (en) begin
      if (cmp_eq) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        case (state_q)
          IDLE: begin
            run_d   = RUN_W'(1);
            state_d = (HOLD == 1) ? STABLE : COUNT;
          end
          COUNT: begin
            run_d = run_q + RUN_W'(1);
            if (run_d == HOLD_R) state_d = STABLE;
          end
          STABLE: begin
            state_d = STABLE;
          end
          default: begin
            state_d = IDLE;
            run_d   = '0;
          end
        endcase
      end else begin
        state_d = IDLE;
        run_d   = '0;
      end
    end

    rise_d = (state_d == STABLE) && (state_q != STABLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign aeqb      = aeqb_q;
  assign agtb      = agtb_q;
  assign altb      = altb_q;
  assign eq_stable = (state_q == STABLE);
  assign eq_rise   = rise_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_eqn_cmp_seq.sv
// Directed bench for eqn_cmp_seq (WIDTH=8, HOLD=3, CNT_W=4); mask scenario only with MATCH_MASK_EN.
module tb_eqn_cmp_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [7:0] a;
  logic [7:0] b;
`ifdef MATCH_MASK_EN
  logic [7:0] mask;
`endif
  logic       aeqb, agtb, altb, eq_stable, eq_rise;
  logic [3:0] match_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eqn_cmp_seq #(
    .WIDTH (8),
    .HOLD  (3),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .a         (a),
    .b         (b),
`ifdef MATCH_MASK_EN
    .mask      (mask),
`endif
    .aeqb      (aeqb),
    .agtb      (agtb),
    .altb      (altb),
    .eq_stable (eq_stable),
    .eq_rise   (eq_rise),
    .match_cnt (match_cnt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;
    logic       e_eq;
    logic       e_gt;
    logic       e_lt;
    logic       e_st;
    logic       e_rise;
    logic [3:0] e_cnt;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic en_i, input logic clr_i,
                              input logic [7:0] a_i, input logic [7:0] b_i,
                              input logic eq_i, input logic gt_i, input logic lt_i,
                              input logic st_i, input logic rise_i, input logic [3:0] cnt_i);
    vec_t v;
    v.rst = rst; v.en = en_i; v.clr = clr_i; v.a = a_i; v.b = b_i;
    v.e_eq = eq_i; v.e_gt = gt_i; v.e_lt = lt_i; v.e_st = st_i; v.e_rise = rise_i; v.e_cnt = cnt_i;
    return v;
  endfunction

  task automatic check(input string tag, input logic e_eq, input logic e_gt, input logic e_lt,
                       input logic e_st, input logic e_rise, input logic [3:0] e_cnt);
    n_vec++;
    if ({aeqb, agtb, altb} !== {e_eq, e_gt, e_lt}) begin
      n_bad++;
      $display("FAIL %s flags eq/gt/lt got %b%b%b want %b%b%b", tag, aeqb, agtb, altb, e_eq, e_gt, e_lt);
    end
    if (eq_stable !== e_st) begin
      n_bad++;
      $display("FAIL %s eq_stable got %b want %b", tag, eq_stable, e_st);
    end
    if (eq_rise !== e_rise) begin
      n_bad++;
      $display("FAIL %s eq_rise got %b want %b", tag, eq_rise, e_rise);
    end
    if (match_cnt !== e_cnt) begin
      n_bad++;
      $display("FAIL %s match_cnt got %0d want %0d", tag, match_cnt, e_cnt);
    end
  endtask

  task automatic drive(input logic rst, input logic en_i, input logic clr_i,
                       input logic [7:0] a_i, input logic [7:0] b_i);
    reset = rst; en = en_i; clr = clr_i; a = a_i; b = b_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst en clr a      b      eq gt lt st rs cnt
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 4'd0);
    vecs[1]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 4'd0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 4'd0);
    vecs[3]  = mk(0, 1, 0, 8'h05, 8'h03, 0, 1, 0, 0, 0, 4'd0);
    vecs[4]  = mk(0, 1, 0, 8'hA5, 8'hA5, 1, 0, 0, 0, 0, 4'd1);
    vecs[5]  = mk(0, 1, 0, 8'hA5, 8'hA5, 1, 0, 0, 0, 0, 4'd2);
    vecs[6]  = mk(0, 1, 0, 8'hA5, 8'hA5, 1, 0, 0, 1, 1, 4'd3);
    vecs[7]  = mk(0, 0, 0, 8'h00, 8'hFF, 1, 0, 0, 1, 0, 4'd3);
    vecs[8]  = mk(0, 1, 0, 8'h01, 8'h02, 0, 0, 1, 0, 0, 4'd3);
    vecs[9]  = mk(0, 1, 0, 8'h22, 8'h22, 1, 0, 0, 0, 0, 4'd4);
    vecs[10] = mk(0, 1, 0, 8'h22, 8'h22, 1, 0, 0, 0, 0, 4'd5);
    vecs[11] = mk(0, 0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 4'd5);
    vecs[12] = mk(0, 0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 4'd5);
    vecs[13] = mk(0, 0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 4'd5);
    vecs[14] = mk(0, 0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 4'd5);
    vecs[15] = mk(0, 1, 0, 8'h22, 8'h22, 1, 0, 0, 1, 1, 4'd6);
    vecs[16] = mk(0, 1, 0, 8'h10, 8'h11, 0, 0, 1, 0, 0, 4'd6);
    vecs[17] = mk(0, 1, 0, 8'h44, 8'h44, 1, 0, 0, 0, 0, 4'd7);
    vecs[18] = mk(0, 1, 0, 8'h44, 8'h44, 1, 0, 0, 0, 0, 4'd8);
    vecs[19] = mk(0, 1, 0, 8'h10, 8'h11, 0, 0, 1, 0, 0, 4'd8);
    vecs[20] = mk(0, 1, 0, 8'h44, 8'h44, 1, 0, 0, 0, 0, 4'd9);
    vecs[21] = mk(0, 1, 0, 8'h44, 8'h44, 1, 0, 0, 0, 0, 4'd10);
    vecs[22] = mk(0, 1, 0, 8'h44, 8'h44, 1, 0, 0, 1, 1, 4'd11);
    vecs[23] = mk(0, 1, 1, 8'h55, 8'h55, 1, 0, 0, 0, 0, 4'd0);
    vecs[24] = mk(0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0, 0, 4'd1);
    vecs[25] = mk(0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0, 0, 4'd2);
    vecs[26] = mk(0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 1, 1, 4'd3);
    vecs[27] = mk(0, 1, 0, 8'h80, 8'h7F, 0, 1, 0, 0, 0, 4'd3);
    vecs[28] = mk(0, 1, 0, 8'h66, 8'h66, 1, 0, 0, 0, 0, 4'd4);
    vecs[29] = mk(0, 1, 0, 8'h66, 8'h66, 1, 0, 0, 0, 0, 4'd5);
    vecs[30] = mk(1, 1, 0, 8'h66, 8'h66, 0, 0, 0, 0, 0, 4'd0);
    vecs[31] = mk(0, 1, 0, 8'h66, 8'h66, 1, 0, 0, 0, 0, 4'd1);
    vecs[32] = mk(0, 1, 0, 8'h66, 8'h66, 1, 0, 0, 0, 0, 4'd2);
    vecs[33] = mk(0, 1, 0, 8'h66, 8'h66, 1, 0, 0, 1, 1, 4'd3);
    vecs[34] = mk(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 4'd0);
    vecs[35] = mk(0, 1, 0, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 4'd0);

    reset = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0;
`ifdef MATCH_MASK_EN
    mask = 8'hFF;
`endif

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), vecs[i].e_eq, vecs[i].e_gt, vecs[i].e_lt,
            vecs[i].e_st, vecs[i].e_rise, vecs[i].e_cnt);
    end

    // Saturation: count stops at 15, eq_rise fires once across the whole run.
    begin
      int rises = 0;
      for (int i = 1; i <= 20; i++) begin
        drive(0, 1, 0, 8'h77, 8'h77);
        if (eq_rise) rises++;
        check($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0, (i >= 3), (i == 3),
              (i >= 15) ? 4'd15 : 4'(i));
      end
      n_vec++;
      if (rises != 1) begin
        n_bad++;
        $display("FAIL sat_rise_count got %0d want 1", rises);
      end
    end

`ifdef MATCH_MASK_EN
    drive(0, 0, 1, 8'h00, 8'h00);
    check("mask_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    mask = 8'hF0;
    drive(0, 1, 0, 8'h3C, 8'h35);
    check("mask_s1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    drive(0, 1, 0, 8'h3C, 8'h35);
    check("mask_s2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    drive(0, 1, 0, 8'h3C, 8'h35);
    check("mask_s3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    mask = 8'hFF;
    drive(0, 1, 0, 8'h3C, 8'h35);
    check("mask_full", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    mask = 8'h00;
    drive(0, 1, 0, 8'h00, 8'hFF);
    check("mask_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
